// File: rtl/stencil_frame_source_if.sv
// Output channels of the stencil frame source: image width, image height and pixel.
// Latency: not applicable, this file only groups the wires.
// Backpressure: each channel uses valid/ready and holds bits stable while valid is high.
interface stencil_frame_source_if;
  logic        imgw_valid;
  logic        imgw_ready;
  logic [15:0] imgw_bits;
  logic        imgh_valid;
  logic        imgh_ready;
  logic [15:0] imgh_bits;
  logic        pixel_valid;
  logic        pixel_ready;
  logic [7:0]  pixel_bits;

  modport master (
    output imgw_valid, imgw_bits, imgh_valid, imgh_bits, pixel_valid, pixel_bits,
    input  imgw_ready, imgh_ready, pixel_ready
  );

  modport slave (
    input  imgw_valid, imgw_bits, imgh_valid, imgh_bits, pixel_valid, pixel_bits,
    output imgw_ready, imgh_ready, pixel_ready
  );
endinterface

// File: rtl/stencil_frame_source.sv
// Frame source for stencil kernels: streams a stored frame as dims + raster pixels, F times (0 = forever).
// Latency: dims valid 1 cycle after accepted start; first pixel the cycle after both dims handshake.
// Backpressure: full valid/ready on all three channels; valids come from state and flags only.
//
// Ports: clock/reset (sync, active-high); wr_en/wr_addr/wr_data load the frame memory in any
// state; cfg_width/cfg_height/cfg_frames are sampled on an accepted start pulse; io_out carries
// the imgw/imgh/pixel channels; busy, done (pulse), err (pulse on rejected start), frames_sent.
module stencil_frame_source #(
  parameter int MAX_PIXELS = 256,
  parameter int ADDR_W     = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [7:0]            wr_data,
  input  logic [15:0]           cfg_width,
  input  logic [15:0]           cfg_height,
  input  logic [31:0]           cfg_frames,
  input  logic                  start,
  stencil_frame_source_if.master io_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [31:0]           frames_sent
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIMS   = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] width_q, width_d;
  logic [15:0] height_q, height_d;
  logic [31:0] frames_cfg_q, frames_cfg_d;
  logic [31:0] npix_q, npix_d;
  logic [31:0] ptr_q, ptr_d;
  logic [31:0] frames_sent_q, frames_sent_d;
  logic        wdone_q, wdone_d;
  logic        hdone_q, hdone_d;
  logic        err_q, err_d;

  logic [7:0]  mem_q [MAX_PIXELS];

  logic [31:0] npix_req;
  logic        imgw_valid, imgh_valid, pixel_valid;
  logic        w_hs, h_hs, p_hs;
  logic        last_pix;
  logic        last_frame;

  // Both factors widened first so the product is formed in 32 bits.
  assign npix_req = 32'(cfg_width) * 32'(cfg_height);

  // Each dims channel drops independently once its own handshake has been recorded.
  assign imgw_valid  = (state_q == S_DIMS) && !wdone_q;
  assign imgh_valid  = (state_q == S_DIMS) && !hdone_q;
  assign pixel_valid = (state_q == S_STREAM);

  assign w_hs = imgw_valid  && io_out.imgw_ready;
  assign h_hs = imgh_valid  && io_out.imgh_ready;
  assign p_hs = pixel_valid && io_out.pixel_ready;

  assign last_pix   = (ptr_q == npix_q - 32'd1);
  assign last_frame = (frames_cfg_q != 32'd0) && (frames_sent_q + 32'd1 == frames_cfg_q);

  assign io_out.imgw_valid  = imgw_valid;
  assign io_out.imgw_bits   = width_q;
  assign io_out.imgh_valid  = imgh_valid;
  assign io_out.imgh_bits   = height_q;
  assign io_out.pixel_valid = pixel_valid;
  // Asynchronous read: a write to the presented address shows up the following cycle.
  assign io_out.pixel_bits  = mem_q[ptr_q[ADDR_W-1:0]];

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign err         = err_q;
  assign frames_sent = frames_sent_q;

  always_comb begin
    state_d       = state_q;
    width_d       = width_q;
    height_d      = height_q;
    frames_cfg_d  = frames_cfg_q;
    npix_d        = npix_q;
    ptr_d         = ptr_q;
    frames_sent_d = frames_sent_q;
    wdone_d       = wdone_q;
    hdone_d       = hdone_q;
    err_d         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if ((npix_req == 32'd0) || (npix_req > 32'(MAX_PIXELS))) begin
            err_d = 1'b1;
          end else begin
            width_d       = cfg_width;
            height_d      = cfg_height;
            frames_cfg_d  = cfg_frames;
            npix_d        = npix_req;
            ptr_d         = 32'd0;
            frames_sent_d = 32'd0;
            wdone_d       = 1'b0;
            hdone_d       = 1'b0;
            state_d       = S_DIMS;
          end
        end
      end

      S_DIMS: begin
        wdone_d = wdone_q | w_hs;
        hdone_d = hdone_q | h_hs;
        if (wdone_d && hdone_d) begin
          // Flags are cleared here so the next frame's DIMS starts with both valids up.
          wdone_d = 1'b0;
          hdone_d = 1'b0;
          state_d = S_STREAM;
        end
      end

      S_STREAM: begin
        if (p_hs) begin
          if (last_pix) begin
            ptr_d         = 32'd0;
            frames_sent_d = frames_sent_q + 32'd1;
            state_d       = last_frame ? S_DONE : S_DIMS;
          end else begin
            ptr_d = ptr_q + 32'd1;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      width_q       <= 16'd0;
      height_q      <= 16'd0;
      frames_cfg_q  <= 32'd0;
      npix_q        <= 32'd0;
      ptr_q         <= 32'd0;
      frames_sent_q <= 32'd0;
      wdone_q       <= 1'b0;
      hdone_q       <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      width_q       <= width_d;
      height_q      <= height_d;
      frames_cfg_q  <= frames_cfg_d;
      npix_q        <= npix_d;
      ptr_q         <= ptr_d;
      frames_sent_q <= frames_sent_d;
      wdone_q       <= wdone_d;
      hdone_q       <= hdone_d;
      err_q         <= err_d;
    end
  end

  // Frame memory keeps its contents across reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

endmodule

// File: doc/stencil_frame_source.md
# stencil_frame_source

Transmitter for the stencil-kernel input protocol. Holds one image frame in local memory and drives the kernel's `imgw`, `imgh` and `pixel` ready/valid channels for a configured number of frames. It replaces hand-indexed pixel arrays in stencil benches and system tops, and sits directly upstream of a kernel such as the Gaussian 3x3. It loads through a simple write port and streams in raster order with full backpressure support.

## Interface
- `MAX_PIXELS`, default 256: frame memory depth, in pixels.
- `ADDR_W`, default 8: memory address width, ≥ clog2(`MAX_PIXELS`).
- `clock` in 1: single clock; all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `wr_en` in 1: memory write strobe.
- `wr_addr` in `ADDR_W`: write address.
- `wr_data` in 8: write pixel.
- `cfg_width` in 16: image width, sampled on accepted `start`.
- `cfg_height` in 16: image height, sampled on accepted `start`.
- `cfg_frames` in 32: frame count, sampled on accepted `start`; 0 means repeat forever.
- `start` in 1: start request, one-cycle pulse.
- `io_out_imgw_valid` out 1, `io_out_imgw_ready` in 1, `io_out_imgw_bits` out 16: width channel.
- `io_out_imgh_valid` out 1, `io_out_imgh_ready` in 1, `io_out_imgh_bits` out 16: height channel.
- `io_out_pixel_valid` out 1, `io_out_pixel_ready` in 1, `io_out_pixel_bits` out 8: pixel channel.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when the last frame completes.
- `err` out 1: one-cycle pulse when `start` is rejected.
- `frames_sent` out 32: count of completed frames since the last accepted `start`.

## Operation
- States: IDLE, DIMS, STREAM, DONE.
- **IDLE.** On `start`:
  - If `W*H == 0` or `W*H > MAX_PIXELS`: pulse `err` next cycle and stay in IDLE.
  - Otherwise latch W, H, F, clear `ptr` and `frames_sent`, and go to DIMS.
- `start` in any other state is ignored.
- **DIMS.** `imgw_valid` and `imgh_valid` both assert on entry.
  - Each channel deasserts independently on the cycle after its own handshake (`valid && ready`).
  - `bits` stay stable while `valid` is high: `imgw_bits` = latched W, `imgh_bits` = latched H.
  - Once both channels have handshaken (same or different cycles), go to STREAM.
- **STREAM.** `pixel_valid` = 1 and `pixel_bits` = `mem[ptr]` (combinational read).
  - On a pixel handshake with `ptr < W*H-1`: `ptr` increments.
  - On a handshake with `ptr == W*H-1`: `ptr` returns to 0 and `frames_sent` increments.
  - After the last pixel: if `F != 0` and `frames_sent+1 == F`, go to DONE; otherwise go to DIMS. Dimensions are resent every frame.
- **DONE.** `done` is high for exactly one cycle, then IDLE. `frames_sent` holds its value until the next accepted `start`.
- Pixel count `W*H` is computed in 32 bits and compared against `MAX_PIXELS`. Memory addresses use the low `ADDR_W` bits of `ptr`.
- Writes are accepted in every state.
  - A write to the address currently being presented changes `pixel_bits` on the next cycle.
  - Changing data under `valid` is the caller's responsibility; the block does not guard against it.
- **Reset.** Reset clears the state to IDLE and zeroes all outputs and counters, even mid-frame. Memory contents are not reset.

## Timing
- Accepted `start` at cycle 0: both dimension valids high at cycle 1.
- DIMS with both readys high at cycle 1: `pixel_valid` high at cycle 2.
- With `pixel_ready` constantly high, one pixel is sent per cycle. A 4x4 frame is pixels at cycles 2..17.
- After the last pixel of a frame, the next cycle is either DIMS (the next frame starts there) or DONE (`done` pulses there).
- Per-frame cost is `W*H` pixel cycles plus 1 DIMS cycle, assuming dimension readys are high.
- No combinational path from any `ready` to any `valid`. Valid depends only on state and on registered handshake flags.

## Test plan
- **Single frame.** Load the 4x4 pattern 0,0,0,0, 0,16,64,0, 0,32,128,0, 0,0,0,0 and start with W=4, H=4, F=1, all readys high.
  - Both dims valid at cycle 1 with bits 4 and 4.
  - Pixels in raster order at cycles 2..17.
  - `done` at cycle 18, `frames_sent` = 1, `busy` low at cycle 19.
- **Backpressure.** Toggle `pixel_ready` pseudo-randomly. All 16 pixels arrive exactly once, in order, with `bits` stable while stalled.
- **Staggered dimensions.** Hold `imgh_ready` low for 3 cycles.
  - `imgw` deasserts after 1 cycle; `imgh` stays valid at 4.
  - STREAM begins only after `imgh` is accepted.
- **Multi-frame and infinite.**
  - F=3: three dims+frame sequences, `frames_sent` steps 1, 2, 3, single `done` pulse.
  - F=0: still streaming after 1000 frames, with `frames_sent` = 1000.
- **Rejected start.** Start with W=0, then with W=32, H=16 (512 > 256).
  - `err` pulses each time; no valid asserts and `busy` stays low.
  - A start issued while `busy` is high is ignored.
- **Reset mid-stream.** Assert `reset` at pixel 7.
  - All valids, `busy` and `frames_sent` are 0 the next cycle.
  - A fresh start replays from pixel 0 with the memory intact.
